// File: rtl/fib_seq_pkg.sv
// rtl/fib_seq_pkg.sv - register map, bit indices and FSM encoding for the Fibonacci sequencer
package fib_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STEPS  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CONT  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/fib_seq_if.sv
// rtl/fib_seq_if.sv - Wishbone slave bus bundle for the Fibonacci sequencer
interface fib_seq_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/fib_seq_regs.sv
// rtl/fib_seq_regs.sv - Wishbone decode, single-cycle ack and register file with W1C status
module fib_seq_regs
  import fib_seq_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             reset,
  fib_seq_if.slave         wb,
  input  logic             busy,
  input  logic             set_done,
  input  logic             set_ovf,
  input  logic             clr_status,
  input  logic             result_we,
  input  logic [WIDTH-1:0] result_d,
  output logic [CNT_W-1:0] steps,
  output logic             continuous,
  output logic             start_pulse,
  output logic             abort_pulse
);

  logic             req;
  logic             hit;
  logic             wr;
  logic [1:0]       off;
  logic             ctrl_wr;
  logic             stat_wr;
  logic [31:0]      wmask;
  logic [31:0]      rdata;
  logic             done;
  logic             overflow;
  logic [WIDTH-1:0] result;
  logic             unused_bits;

  // ack low in the request's first cycle gates a new request, giving one ack per two cycles
  assign req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o;
  assign hit     = (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr      = req & hit & wb.wbs_we_i;
  assign off     = wb.wbs_adr_i[3:2];
  assign ctrl_wr = wr & (off == REG_CTRL) & wb.wbs_sel_i[0];
  assign stat_wr = wr & (off == REG_STATUS) & wb.wbs_sel_i[0];
  assign wmask   = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                    {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};

  assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i, wmask};

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:   rdata[CTRL_CONT] = continuous;
      REG_STEPS:  rdata[CNT_W-1:0] = steps;
      REG_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done;
        rdata[STAT_OVF]  = overflow;
      end
      default:    rdata[WIDTH-1:0] = result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      steps        <= '0;
      continuous   <= 1'b0;
      start_pulse  <= 1'b0;
      abort_pulse  <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      result       <= '0;
    end else begin
      wb.wbs_ack_o <= req;
      if (req) begin
        wb.wbs_dat_o <= (hit && !wb.wbs_we_i) ? rdata : '0;
      end

      // abort takes priority over a start carried in the same write
      start_pulse <= ctrl_wr & wb.wbs_dat_i[CTRL_START] & ~wb.wbs_dat_i[CTRL_ABORT];
      abort_pulse <= ctrl_wr & wb.wbs_dat_i[CTRL_ABORT];
      if (ctrl_wr) begin
        continuous <= wb.wbs_dat_i[CTRL_CONT];
      end

      if (wr && off == REG_STEPS) begin
        steps <= (steps & ~wmask[CNT_W-1:0]) | (wb.wbs_dat_i[CNT_W-1:0] & wmask[CNT_W-1:0]);
      end

      // a hardware set beats a coincident software clear
      if (set_done) begin
        done <= 1'b1;
      end else if (clr_status || (stat_wr && wb.wbs_dat_i[STAT_DONE])) begin
        done <= 1'b0;
      end

      if (set_ovf) begin
        overflow <= 1'b1;
      end else if (clr_status || (stat_wr && wb.wbs_dat_i[STAT_OVF])) begin
        overflow <= 1'b0;
      end

      if (result_we) begin
        result <= result_d;
      end
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - runs the Fibonacci core for N steps or continuously and captures the result
module fib_sequencer
  import fib_seq_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          STOP_ON_OVF = 0
) (
  input  logic             clk,
  input  logic             reset,
  fib_seq_if.slave         wb,
  input  logic [WIDTH-1:0] fib_value,
  output logic             fib_clear,
  output logic             fib_step,
  output logic             busy,
  output logic             done_pulse
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] prev;
  logic             run_cont;
  logic             continuous;
  logic             start_pulse;
  logic             abort_pulse;
  logic             ovf_now;
  logic             set_done;
  logic             clr_status;
  logic             result_we;

  fib_seq_regs #(
    .WIDTH     (WIDTH),
    .CNT_W     (CNT_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb),
    .busy        (busy),
    .set_done    (set_done),
    .set_ovf     (ovf_now),
    .clr_status  (clr_status),
    .result_we   (result_we),
    .result_d    (fib_value),
    .steps       (steps),
    .continuous  (continuous),
    .start_pulse (start_pulse),
    .abort_pulse (abort_pulse)
  );

  assign busy    = (state != ST_IDLE);
  assign ovf_now = (state == ST_RUN || state == ST_CAPTURE) && (fib_value < prev);

  always_comb begin
    state_nxt  = state;
    fib_clear  = 1'b0;
    fib_step   = 1'b0;
    done_pulse = 1'b0;
    set_done   = 1'b0;
    result_we  = 1'b0;
    clr_status = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_pulse) begin
          state_nxt  = ST_CLEAR;
          clr_status = 1'b1;
        end
      end
      ST_CLEAR: begin
        fib_clear = 1'b1;
        state_nxt = (counter == '0 && !run_cont) ? ST_CAPTURE : ST_RUN;
      end
      ST_RUN: begin
        // holding the step back keeps the wrapped value on the core for capture
        if (STOP_ON_OVF != 0 && ovf_now) begin
          state_nxt = ST_CAPTURE;
        end else begin
          fib_step  = 1'b1;
          result_we = run_cont;
          if (!run_cont && counter == CNT_W'(1)) begin
            state_nxt = ST_CAPTURE;
          end
        end
      end
      default: begin
        result_we  = 1'b1;
        set_done   = 1'b1;
        done_pulse = 1'b1;
        state_nxt  = ST_IDLE;
      end
    endcase
    if (abort_pulse && state != ST_IDLE) begin
      state_nxt  = ST_IDLE;
      fib_clear  = 1'b0;
      fib_step   = 1'b0;
      done_pulse = 1'b0;
      set_done   = 1'b0;
      result_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      counter  <= '0;
      prev     <= '0;
      run_cont <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start_pulse) begin
        counter  <= steps;
        run_cont <= continuous;
      end else if (state == ST_RUN) begin
        counter <= counter - 1'b1;
      end
      if (state == ST_CLEAR) begin
        prev <= '0;
      end else if (state == ST_RUN || state == ST_CAPTURE) begin
        prev <= fib_value;
      end
    end
  end

endmodule

// File: doc/fib_sequencer.md
Name: fib_sequencer

Overview:
Wishbone-controlled sequencer for a steppable Fibonacci datapath core. It clears the core, advances it exactly N steps or continuously, and captures the resulting value. It also flags arithmetic wrap-around and reports busy/done status. It sits between the user-area Wishbone slave port and the Fibonacci core, replacing free-running operation with software-controlled runs.

Parameters:
WIDTH, 32, datapath width of the core value / RESULT register
CNT_W, 16, width of the step counter and STEPS register
BASE_ADDR, 32'h3000_0000, Wishbone base address; register decode on wbs_adr_i[31:4] == BASE_ADDR[31:4]
STOP_ON_OVF, 0, 1 = an overflow ends the run like an abort, with done set

Ports:
clk  input  1  system clock (wb_clk_i at top level)
reset  input  1  synchronous, active-high reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  Wishbone write enable
wbs_sel_i  input  4  byte selects; a byte lane is written only when its select bit is 1
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  registered acknowledge
wbs_dat_o  output  32  registered read data
fib_value  input  WIDTH  current core value; updates the cycle after fib_step/fib_clear
fib_clear  output  1  synchronous clear to the core; after clear, value = 0 and next step yields 1
fib_step  output  1  advance the core by one term on this clock edge
busy  output  1  high in any state except IDLE
done_pulse  output  1  one-cycle pulse when a run completes

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state=IDLE. The following all reset to 0: STEPS, RESULT, counter, CTRL.continuous, STATUS.done, STATUS.overflow, prev register, wbs_ack_o, wbs_dat_o, fib_clear, fib_step, busy, done_pulse.
- Registers (offset = adr[3:2]):
  - 0x0 CTRL:
    - W bit0 = start (self-clearing), bit1 = abort (self-clearing), bit2 = continuous.
    - R returns {29'b0, continuous, 2'b0}.
  - 0x4 STEPS: RW, CNT_W bits, zero-extended on read.
  - 0x8 STATUS:
    - R {29'b0, overflow, done, busy}.
    - W1C on done (bit1) and overflow (bit2).
  - 0xC RESULT: RO, WIDTH bits zero-extended; writes ignored.
- Wishbone timing:
  - ack asserts the cycle after stb&cyc&!ack and stays high for exactly 1 cycle.
  - Read data is valid with ack; the write takes effect on the same edge ack rises.
  - Back-to-back requests are acked every other cycle.
  - Unmapped or off-base addresses are still acked; they read 0 and writes have no effect.
- FSM states: IDLE, CLEAR, RUN, CAPTURE.
  - IDLE: start → CLEAR. On that transition: counter<=STEPS, done<=0, overflow<=0.
  - CLEAR: fib_clear=1 for 1 cycle; prev<=0; next state RUN, or CAPTURE if counter==0 and !continuous.
  - RUN: fib_step=1 every cycle and counter decrements each cycle. When counter==1 and !continuous, the last step issues and the FSM goes to CAPTURE.
  - RUN, continuous mode: RESULT<=fib_value every cycle. Stays in RUN until abort.
  - CAPTURE: no step. RESULT<=fib_value, done<=1, done_pulse=1, then IDLE.
- Latency: start write ack edge → CLEAR next cycle. RESULT is valid N+3 cycles after the start ack edge; done rises on the same edge.
- Overflow detect:
  - During RUN and CAPTURE, if fib_value < prev, set overflow (sticky); prev<=fib_value every cycle.
  - STOP_ON_OVF=1: go to CAPTURE immediately and capture the wrapped value.
- Boundary conditions:
  - Start while busy: ignored.
  - Start and abort in the same write: abort wins, so the FSM stays IDLE.
  - Abort in CLEAR/RUN/CAPTURE: IDLE next cycle; done not set; RESULT keeps its last captured value.
  - STEPS written while busy: stored, used at the next start.
  - CTRL.continuous changed mid-run: sampled only at start.
  - W1C of done coinciding with a done set: set wins.
  - Reset mid-run: immediate return to reset values; fib_clear is not issued.

Decomposition:
- Package fib_seq_pkg: register offsets (CTRL/STEPS/STATUS/RESULT), CTRL/STATUS bit indices, FSM state enum (2-bit).
- Natural sub-module: fib_seq_regs, holding the Wishbone decode, ack generation, register file and W1C logic. The top level holds the FSM, counter and overflow logic.

Test Plan:
- Reset, then read all 4 registers → all 0, and ack is exactly 1 cycle wide per access.
- STEPS=10, CTRL=1 → busy for 12 cycles, done_pulse once, RESULT=55, STATUS=0x2.
- STEPS=0, start → RESULT=0, done=1 after 2 busy cycles; fib_step is never asserted.
- WIDTH=8, STEPS=14 → overflow=1 (377 wraps to 121), RESULT=121. With STOP_ON_OVF=1, done and RESULT=121 occur at the wrap cycle.
- Continuous start, abort after 20 cycles → busy drops the next cycle, done=0, RESULT equals the last sampled value.
- Start during a run → ignored. Start+abort write (CTRL=3) → stays IDLE. Reset asserted mid-RUN → all outputs 0 on the next edge. W1C STATUS=0x6 → done and overflow cleared.
